// File: rtl/fn_sw_pkg.sv
// Shared types and constants for the fu_sw truth-table sweep engine.
package fn_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] FN_SW_EXPECT = 16'h96E8;
  localparam int          FN_SW_IDX_W  = 4;
  localparam int          FN_SW_ERR_W  = 5;

  // Mismatch count after one more sample; 16 samples max, so 5 bits never overflow.
  function automatic logic [FN_SW_ERR_W-1:0] err_step(input logic [FN_SW_ERR_W-1:0] cnt,
                                                      input logic mism);
    return cnt + {{(FN_SW_ERR_W-1){1'b0}}, mism};
  endfunction

endpackage

// File: rtl/fn_sw_scan_if.sv
// Handshake and result bundle between the sweep engine and fu_sw / its requester.
interface fn_sw_scan_if;
  import fn_sw_pkg::*;

  logic                   start;
  logic                   y_i;
  logic                   a_o;
  logic                   b_o;
  logic [1:0]             sel_o;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [15:0]            tbl;
  logic [FN_SW_ERR_W-1:0] err_cnt;

  modport master (
    input  start, y_i,
    output a_o, b_o, sel_o, busy, done, pass, tbl, err_cnt
  );

  modport slave (
    output start, y_i,
    input  a_o, b_o, sel_o, busy, done, pass, tbl, err_cnt
  );

endinterface

// File: rtl/fn_sw_scan_timer.sv
// Settle counter: hit is high while the count equals SETTLE-1.
module fn_sw_scan_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [W-1:0] cnt;

  // Clear has priority so the cycle that hits also rearms the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign hit = (cnt == W'(SETTLE - 1));

endmodule

// File: rtl/fn_sw_scan.sv
// Drives fu_sw through all 16 {sel,b,a} inputs, captures y and grades it against EXPECT.
module fn_sw_scan
  import fn_sw_pkg::*;
#(
  parameter int          SETTLE = 1,
  parameter logic [15:0] EXPECT = FN_SW_EXPECT
) (
  input logic          clk,
  input logic          rst,
  fn_sw_scan_if.master bus
);

  state_t                 state;
  state_t                 state_nx;
  logic [FN_SW_IDX_W-1:0] idx;
  logic                   t_clr;
  logic                   t_en;
  logic                   t_hit;
  logic                   accept;
  logic                   sample;
  logic                   mism;
  logic [FN_SW_ERR_W-1:0] err_nx;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [15:0]            tbl;
  logic [FN_SW_ERR_W-1:0] err_cnt;

  fn_sw_scan_timer #(.SETTLE(SETTLE)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (t_clr),
    .en  (t_en),
    .hit (t_hit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nx = state;
    t_clr    = 1'b0;
    t_en     = 1'b0;
    accept   = 1'b0;
    sample   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_WAIT;
          t_clr    = 1'b1;
          accept   = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        t_en = 1'b1;
        if (t_hit) begin
          state_nx = ST_SAMPLE;
          t_clr    = 1'b1;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (idx == 4'd15) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign mism   = bus.y_i ^ EXPECT[idx];
  assign err_nx = err_step(err_cnt, mism);

  // Datapath; pass is graded from the count that already includes the final sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      tbl     <= 16'h0000;
      err_cnt <= '0;
      pass    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nx == ST_WAIT) || (state_nx == ST_SAMPLE);
      done <= (state_nx == ST_DONE);
      if (accept) begin
        idx     <= '0;
        tbl     <= 16'h0000;
        err_cnt <= '0;
        pass    <= 1'b0;
      end else if (sample) begin
        tbl[idx] <= bus.y_i;
        err_cnt  <= err_nx;
        if (idx == 4'd15) begin
          pass <= (err_nx == 5'd0);
        end else begin
          idx <= idx + 4'd1;
        end
      end else begin
        idx <= idx;
      end
    end
  end

  assign bus.a_o     = idx[0];
  assign bus.b_o     = idx[1];
  assign bus.sel_o   = idx[3:2];
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.pass    = pass;
  assign bus.tbl     = tbl;
  assign bus.err_cnt = err_cnt;

endmodule

// File: tb/tb_fn_sw_scan.sv
// Scoreboard bench: two engines (SETTLE=1 and SETTLE=3) around a behavioural fu_sw with fault modes.
module tb_fn_sw_scan;

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  err;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   mode1 = 0;
  int   mode3 = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1;
  exp_t e3;

  fn_sw_scan_if bus1 ();
  fn_sw_scan_if bus3 ();

  fn_sw_scan #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fn_sw_scan #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fu_sw: 0=AND 1=OR 2=XOR 3=XNOR. mode 1 stuck-0, 2 stuck-1, 3 inverted XNOR.
  function automatic logic fu_model(input logic [1:0] sel, input logic b, input logic a, input int mode);
    logic y;
    case (sel)
      2'd0:    y = a & b;
      2'd1:    y = a | b;
      2'd2:    y = a ^ b;
      default: y = ~(a ^ b);
    endcase
    if (mode == 1) y = 1'b0;
    else if (mode == 2) y = 1'b1;
    else if (mode == 3 && sel == 2'd3) y = ~y;
    return y;
  endfunction

  always_comb bus1.y_i = fu_model(bus1.sel_o, bus1.b_o, bus1.a_o, mode1);
  always_comb bus3.y_i = fu_model(bus3.sel_o, bus3.b_o, bus3.a_o, mode3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge right after the accepting edge.
  task automatic start_sweep(input int which, input bit push, input logic [15:0] etbl,
                             input logic epass, input logic [4:0] eerr);
    exp_t e;
    int   s;
    @(negedge clk);
    if (which == 1) bus1.start = 1'b1; else bus3.start = 1'b1;
    s = (which == 1) ? 1 : 3;
    e.tbl = etbl; e.pass = epass; e.err = eerr;
    e.done_cyc = cyc + 1 + 16 * (s + 1);
    if (push) begin
      if (which == 1) q1.push_back(e); else q3.push_back(e);
    end
    @(negedge clk);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic wait_done(input int which);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 1) ? bus1.done : bus3.done;
    end
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_abs"}, {29'd0, bus1.sel_o, bus1.b_o, bus1.a_o}, 32'd0);
    check({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    check({tag, "_done"}, 32'(bus1.done), 32'd0);
    check({tag, "_pass"}, 32'(bus1.pass), 32'd0);
    check({tag, "_tbl"}, 32'(bus1.tbl), 32'd0);
    check({tag, "_err"}, 32'(bus1.err_cnt), 32'd0);
  endtask

  // Scoreboard monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (bus1.done) begin
      check("done1_expected", 32'(q1.size() > 0), 32'd1);
      check("done1_busy_low", 32'(bus1.busy), 32'd0);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("sw1_tbl", 32'(bus1.tbl), 32'(e1.tbl));
        check("sw1_pass", 32'(bus1.pass), 32'(e1.pass));
        check("sw1_err", 32'(bus1.err_cnt), 32'(e1.err));
        check("sw1_done_cyc", 32'(cyc), 32'(e1.done_cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus3.done) begin
      check("done3_expected", 32'(q3.size() > 0), 32'd1);
      check("done3_busy_low", 32'(bus3.busy), 32'd0);
      if (q3.size() > 0) begin
        e3 = q3.pop_front();
        check("sw3_tbl", 32'(bus3.tbl), 32'(e3.tbl));
        check("sw3_pass", 32'(bus3.pass), 32'(e3.pass));
        check("sw3_err", 32'(bus3.err_cnt), 32'(e3.err));
        check("sw3_done_cyc", 32'(cyc), 32'(e3.done_cyc));
      end
    end
  end

  initial begin
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset3_busy", 32'(bus3.busy), 32'd0);
    rst = 1'b0;

    // Golden sweep with input stepping: each index held 2 cycles, idx held at 15 in DONE.
    start_sweep(1, 1'b1, 16'h96E8, 1'b1, 5'd8 - 5'd8);
    for (int j = 0; j < 32; j++) begin
      check("step_abs", {29'd0, bus1.sel_o, bus1.b_o, bus1.a_o}, 32'(j / 2));
      check("step_busy", 32'(bus1.busy), 32'd1);
      @(negedge clk);
    end
    check("done_idx15", {29'd0, bus1.sel_o, bus1.b_o, bus1.a_o}, 32'd15);
    check("done_pulse", 32'(bus1.done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus1.done), 32'd0);
    check("idle_idx15", {29'd0, bus1.sel_o, bus1.b_o, bus1.a_o}, 32'd15);

    // Fault models.
    mode1 = 1; start_sweep(1, 1'b1, 16'h0000, 1'b0, 5'd8); wait_done(1);
    mode1 = 2; start_sweep(1, 1'b1, 16'hFFFF, 1'b0, 5'd8); wait_done(1);
    mode1 = 3; start_sweep(1, 1'b1, 16'h66E8, 1'b0, 5'd4); wait_done(1);
    mode1 = 0;

    // Start pulses while busy must be ignored: one done, unchanged timing.
    start_sweep(1, 1'b1, 16'h96E8, 1'b1, 5'd0);
    repeat (3) @(negedge clk);
    bus1.start = 1'b1; @(negedge clk); bus1.start = 1'b0;
    repeat (14) @(negedge clk);
    bus1.start = 1'b1; @(negedge clk); bus1.start = 1'b0;
    wait_done(1);
    repeat (40) @(negedge clk);
    check("busy_start_no_rerun", 32'(bus1.busy), 32'd0);

    // Reset mid-sweep at idx 7: immediate clear, no done, clean restart.
    start_sweep(1, 1'b0, 16'h0000, 1'b0, 5'd0);
    for (int i = 0; i < 40 && {bus1.sel_o, bus1.b_o, bus1.a_o} != 4'd7; i++) @(negedge clk);
    check("reached_idx7", {28'd0, bus1.sel_o, bus1.b_o, bus1.a_o}, 32'd7);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(bus1.busy), 32'd0);
    start_sweep(1, 1'b1, 16'h96E8, 1'b1, 5'd0);
    wait_done(1);

    // SETTLE=3, back-to-back sweeps.
    start_sweep(3, 1'b1, 16'h96E8, 1'b1, 5'd0);
    wait_done(3);
    start_sweep(3, 1'b1, 16'h96E8, 1'b1, 5'd0);
    check("b2b_tbl_clr", 32'(bus3.tbl), 32'd0);
    check("b2b_err_clr", 32'(bus3.err_cnt), 32'd0);
    check("b2b_pass_clr", 32'(bus3.pass), 32'd0);
    check("b2b_busy", 32'(bus3.busy), 32'd1);
    wait_done(3);

    for (int i = 0; i < 200 && (q1.size() + q3.size()) != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(q1.size() + q3.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fn_sw_scan.md
# fn_sw_scan

Truth-table sweep engine for the `fu_sw` function switch, sitting directly around it: it drives `fu_sw`'s `a`/`b`/`sel` inputs through all 16 combinations and samples the returned `y`. On each `start` it builds a 16-bit table, compares it against the golden function map and reports pass/fail plus a mismatch count. It replaces the free-running bench counter with a synthesizable, handshaked self-test stage.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each input combination is held before `y_i` is sampled; must be ≥1.
- `EXPECT`, default 16'h96E8: golden table, indexed `{sel,b,a}`. Nibbles are AND=8, OR=E, XOR=6, XNOR=9.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; accepted only in IDLE.
- `y_i` input 1: result returned from `fu_sw`.
- `a_o` input-drive output 1: `fu_sw.a`, equals `idx[0]`.
- `b_o` output 1: `fu_sw.b`, equals `idx[1]`.
- `sel_o` output 2: `fu_sw.sel`, equals `idx[3:2]`.
- `busy` output 1: high in WAIT and SAMPLE.
- `done` output 1: one-cycle pulse at sweep end.
- `pass` output 1: `table == EXPECT`; valid from `done`, held until next accepted `start`.
- `table` output 16: captured `y` per index.
- `err_cnt` output 5: number of bits of `table` differing from `EXPECT` (0–16).

## Operation
- Registered state: `state`, `idx[3:0]`, settle counter `wcnt`, `table`, `err_cnt`, `pass`.
- `a_o`/`b_o`/`sel_o` decode directly from the `idx` register. They are glitch-free and change only on clock edges.
- States:
  - IDLE → WAIT on `start`. On that edge: `idx`=0, `wcnt`=0, `table`=0, `err_cnt`=0, `pass`=0.
  - WAIT: `wcnt` increments each cycle. When `wcnt==SETTLE-1`, go to SAMPLE and clear `wcnt`.
  - SAMPLE: `table[idx]` ← `y_i`. `err_cnt` increments if `y_i != EXPECT[idx]`. If `idx==15`, go to DONE; otherwise `idx`++ and go to WAIT.
  - DONE: `done`=1 for exactly this cycle. `pass` ← (`err_cnt==0`), using the final count including the last sample, so it is registered at the SAMPLE→DONE edge. Next state is IDLE.
- `idx` never wraps during a sweep; it stays at 15 through DONE and IDLE until the next `start`.
- `start` is ignored in WAIT, SAMPLE and DONE. No queueing.
- `err_cnt` saturates naturally at 16, which needs 5 bits and cannot overflow.

## Timing
- Reset value of every output is 0: `a_o`, `b_o`, `sel_o`, `busy`, `done`, `pass`, `table`, `err_cnt`. State resets to IDLE, `idx` to 0.
- Each index occupies SETTLE+1 cycles: SETTLE cycles in WAIT, then 1 in SAMPLE.
- `start` is sampled at edge k. `done` is high in the cycle following edge k+16·(SETTLE+1).
  - SETTLE=1: `done` is 32 cycles after acceptance.
- `busy` rises at edge k. It falls at the edge entering DONE, so `busy` and `done` are never high together.
- `y_i` is assumed combinational from `a_o`/`b_o`/`sel_o` within the SETTLE window. It is sampled only in SAMPLE.
- `start` in the IDLE cycle right after DONE is accepted, giving back-to-back sweeps with a one-cycle gap.
- Reset asserted mid-sweep:
  - Immediately forces IDLE and clears all outputs, with no `done` pulse.
  - Deassertion is synchronized by the existing reset scheme.
  - The first edge after release is IDLE.

## Structure
- Shared package `fn_sw_pkg` holds:
  - the state encoding (IDLE/WAIT/SAMPLE/DONE);
  - `FN_SW_EXPECT = 16'h96E8`;
  - `FN_SW_IDX_W = 4`.
- Sub-module `fn_sw_scan_timer` is the SETTLE counter: `clr`/`en` inputs, `hit` output when the count equals SETTLE-1.
- Top-level integration instantiates `fn_sw_scan` beside `fu_sw`, wiring `a_o`/`b_o`/`sel_o` into `fu_sw` and its `y` back to `y_i`.

## Test plan
- **Golden sweep.** Reset, then `start` with a correct `fu_sw`, SETTLE=1.
  - `done` arrives 32 cycles after acceptance.
  - `table`=16'h96E8, `pass`=1, `err_cnt`=0.
  - `{sel_o,b_o,a_o}` steps 0..15, each value held 2 cycles.
- **Stuck-at-0.** Tie `y_i`=0 → `table`=16'h0000, `pass`=0, `err_cnt`=8.
- **Stuck-at-1 and bit flip.**
  - Tie `y_i`=1 → `table`=16'hFFFF, `err_cnt`=8, `pass`=0.
  - Invert only the XNOR (sel=3) path → `table`=16'h66E8, `err_cnt`=4.
- **Start while busy.** Pulse `start` on cycles 5 and 20 of a sweep → ignored; exactly one `done`, timing unchanged.
- **Reset mid-sweep.** Assert `rst` while `idx`=7 → all outputs 0 in the same cycle, no `done`. Restart then completes with `pass`=1.
- **Longer settle, back-to-back.** SETTLE=3: `done` arrives 64 cycles after `start`. Issuing `start` in the cycle after `done` gives `table` and `err_cnt` cleared on acceptance and a second, identical result.
